// File: rtl/pattern_serializer.sv
// pattern_serializer
// Parallel-to-serial feeder for the pattern detector. Accepts WIDTH-bit words
// over a valid/ready handshake and emits one bit per advance on data_o.
// Back-to-back words stream with no idle bit in between, so patterns that
// straddle a word boundary arrive at the detector intact.
//
// Parameters
//   WIDTH     word width in bits (>= 2)
//   MSB_FIRST 1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
//
// Ports
//   clk_i        single clock, rising edge
//   reset_i      synchronous active-low reset
//   word_i       parallel word to serialize
//   valid_i      word_i is valid
//   ready_o      word can be accepted this cycle (combinational from state)
//   bit_en_i     advance qualifier (tie high when feeding the detector)
//   data_o       serial bit (registered)
//   bit_valid_o  data_o carries a word bit (registered)
//   frame_o      data_o is the first bit of a word (registered)
module pattern_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             bit_en_i,
  output logic             data_o,
  output logic             bit_valid_o,
  output logic             frame_o
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] shreg_r, shreg_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic             data_r, data_nxt_s;
  logic             bit_valid_r, bit_valid_nxt_s;
  logic             frame_r, frame_nxt_s;
  logic             last_bit_s;
  logic             accept_s;

  // Bit that sits at the send end of a word.
  function automatic logic send_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Move the word one position toward the send end, filling with zero.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // The last bit of the current word is about to retire on this edge, which
  // is the only moment a new word can be chained in without a gap.
  assign last_bit_s = (state_r == ST_SHIFT) && (cnt_r == CNT_LAST) && bit_en_i;
  assign ready_o    = (state_r == ST_IDLE) || last_bit_s;
  assign accept_s   = valid_i && ready_o;

  assign data_o      = data_r;
  assign bit_valid_o = bit_valid_r;
  assign frame_o     = frame_r;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_r     <= ST_IDLE;
      shreg_r     <= {WIDTH{1'b0}};
      cnt_r       <= CNT_ZERO;
      data_r      <= 1'b0;
      bit_valid_r <= 1'b0;
      frame_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      shreg_r     <= shreg_nxt_s;
      cnt_r       <= cnt_nxt_s;
      data_r      <= data_nxt_s;
      bit_valid_r <= bit_valid_nxt_s;
      frame_r     <= frame_nxt_s;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_bit_s && !accept_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the shift register, bit counter and registered outputs.
  always_comb begin
    shreg_nxt_s     = shreg_r;
    cnt_nxt_s       = cnt_r;
    data_nxt_s      = data_r;
    bit_valid_nxt_s = bit_valid_r;
    frame_nxt_s     = frame_r;
    if (accept_s) begin
      // Load from IDLE or chained after the last bit: identical behaviour.
      shreg_nxt_s     = word_i;
      cnt_nxt_s       = CNT_ZERO;
      data_nxt_s      = send_bit(word_i);
      bit_valid_nxt_s = 1'b1;
      frame_nxt_s     = 1'b1;
    end else if ((state_r == ST_IDLE) || last_bit_s) begin
      // Line rests at zero between words.
      data_nxt_s      = 1'b0;
      bit_valid_nxt_s = 1'b0;
      frame_nxt_s     = 1'b0;
    end else if (bit_en_i) begin
      shreg_nxt_s     = shift_word(shreg_r);
      cnt_nxt_s       = cnt_r + CNT_ONE;
      data_nxt_s      = send_bit(shift_word(shreg_r));
      bit_valid_nxt_s = 1'b1;
      frame_nxt_s     = 1'b0;
    end else begin
      // Stalled: the current bit stays on the line.
      shreg_nxt_s     = shreg_r;
      cnt_nxt_s       = cnt_r;
      data_nxt_s      = data_r;
      bit_valid_nxt_s = bit_valid_r;
      frame_nxt_s     = frame_r;
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
module tb_pattern_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         valid_i;
  logic         bit_en_i;
  logic [W-1:0] word_i;

  logic ready_m, data_m, bv_m, fr_m;
  logic ready_l, data_l, bv_l, fr_l;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: whether a word is in flight, which bit index is on the line.
  bit           m_busy = 1'b0;
  int           m_idx  = 0;
  logic [W-1:0] m_word = '0;

  // Bits seen on the line at the cycle they retire (bit_en high).
  logic cap_m[$];
  logic cap_l[$];
  logic cap_f[$];

  always #5 clk = ~clk;

  pattern_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk_i(clk), .reset_i(reset_i), .word_i(word_i), .valid_i(valid_i),
    .ready_o(ready_m), .bit_en_i(bit_en_i), .data_o(data_m),
    .bit_valid_o(bv_m), .frame_o(fr_m)
  );

  pattern_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk_i(clk), .reset_i(reset_i), .word_i(word_i), .valid_i(valid_i),
    .ready_o(ready_l), .bit_en_i(bit_en_i), .data_o(data_l),
    .bit_valid_o(bv_l), .frame_o(fr_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: words are tracked by index, not by shifting.
  always @(posedge clk) begin
    if (!reset_i) begin
      m_busy <= 1'b0;
      m_idx  <= 0;
    end else if (!m_busy) begin
      if (valid_i) begin
        m_busy <= 1'b1;
        m_word <= word_i;
        m_idx  <= 0;
      end
    end else if (bit_en_i) begin
      if (m_idx < W - 1) begin
        m_idx <= m_idx + 1;
      end else if (valid_i) begin
        m_word <= word_i;
        m_idx  <= 0;
      end else begin
        m_busy <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, plus bit capture.
  always @(negedge clk) begin
    logic exp_rdy, exp_dm, exp_dl, exp_fr;
    exp_rdy = !m_busy || ((m_idx == W - 1) && bit_en_i);
    exp_dm  = m_busy ? m_word[W-1-m_idx] : 1'b0;
    exp_dl  = m_busy ? m_word[m_idx] : 1'b0;
    exp_fr  = m_busy && (m_idx == 0);
    if (chk_en) begin
      check("ready_msb", ready_m, exp_rdy);
      check("data_msb", data_m, exp_dm);
      check("bvalid_msb", bv_m, m_busy);
      check("frame_msb", fr_m, exp_fr);
      check("ready_lsb", ready_l, exp_rdy);
      check("data_lsb", data_l, exp_dl);
      check("bvalid_lsb", bv_l, m_busy);
      check("frame_lsb", fr_l, exp_fr);
    end
    if (bv_m && bit_en_i) begin
      cap_m.push_back(data_m);
      cap_f.push_back(fr_m);
    end
    if (bv_l && bit_en_i) begin
      cap_l.push_back(data_l);
    end
  end

  // Present a word and hold it until accepted; returns #1 into the first bit cycle.
  task automatic send(input logic [W-1:0] w);
    int n;
    n = 0;
    valid_i = 1'b1;
    word_i  = w;
    @(negedge clk);
    while (!ready_m && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_m) begin
      errors++;
      $display("FAIL send_timeout: got ready 0 expected 1 for word %0h", w);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    word_i  = W'($urandom);
  endtask

  task automatic wait_caps(input int n);
    int t;
    t = 0;
    while (cap_m.size() < n && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("capture_count", cap_m.size(), n);
  endtask

  function automatic logic [15:0] grab(input int which, input int start, input int n);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < n; i++) begin
      case (which)
        0:       r = {r[14:0], cap_m[start+i]};
        1:       r = {r[14:0], cap_l[start+i]};
        default: r = {r[14:0], cap_f[start+i]};
      endcase
    end
    return r;
  endfunction

  initial begin
    int s;
    reset_i  = 1'b0;
    valid_i  = 1'b1;
    word_i   = 8'hFF;
    bit_en_i = 1'b1;

    // Reset held two edges with valid high: nothing accepted.
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    check("rst_data", data_m, 1'b0);
    check("rst_bvalid", bv_m, 1'b0);
    check("rst_frame", fr_m, 1'b0);
    check("rst_data_lsb", data_l, 1'b0);
    valid_i = 1'b0;
    reset_i = 1'b1;
    #1;
    check("rst_ready", ready_m, 1'b1);

    // Single word 1011_0010.
    s = cap_m.size();
    send(8'b1011_0010);
    check("single_frame_first", fr_m, 1'b1);
    check("single_bvalid_first", bv_m, 1'b1);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    check("single_ready_last", ready_m, 1'b1);
    @(posedge clk);
    #1;
    check("single_idle_bvalid", bv_m, 1'b0);
    check("single_idle_data", data_m, 1'b0);
    check("single_bits_msb", grab(0, s, 8), 16'h00B2);
    check("single_bits_lsb", grab(1, s, 8), 16'h004D);
    check("single_frames", grab(2, s, 8), 16'h0080);

    // Back-to-back A5 then 3C.
    repeat (2) @(posedge clk);
    #1;
    s = cap_m.size();
    send(8'hA5);
    send(8'h3C);
    wait_caps(s + 16);
    check("b2b_bits_msb", grab(0, s, 16), 16'hA53C);
    check("b2b_bits_lsb", grab(1, s, 16), 16'hA53C);
    check("b2b_frames", grab(2, s, 16), 16'h8080);

    // Stall three cycles at bit 3, with a competing word offered meanwhile.
    repeat (2) @(posedge clk);
    #1;
    s = cap_m.size();
    send(8'b1011_0010);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bit_en_i = 1'b0;
    valid_i  = 1'b1;
    word_i   = 8'h00;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_data_msb", data_m, 1'b1);
      check("stall_data_lsb", data_l, 1'b0);
      check("stall_ready", ready_m, 1'b0);
      @(posedge clk);
      #1;
    end
    bit_en_i = 1'b1;
    valid_i  = 1'b0;
    #1;
    check("stall_data_4th", data_m, 1'b1);
    wait_caps(s + 8);
    check("stall_bits_msb", grab(0, s, 8), 16'h00B2);
    check("stall_bits_lsb", grab(1, s, 8), 16'h004D);

    // Reset mid-word, then a clean word.
    repeat (2) @(posedge clk);
    #1;
    send(8'hFF);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    reset_i = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_data", data_m, 1'b0);
    check("midrst_bvalid", bv_m, 1'b0);
    check("midrst_frame", fr_m, 1'b0);
    reset_i = 1'b1;
    s = cap_m.size();
    send(8'h01);
    wait_caps(s + 8);
    check("midrst_bits_msb", grab(0, s, 8), 16'h0001);
    check("midrst_bits_lsb", grab(1, s, 8), 16'h0080);

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      valid_i  = ($urandom_range(0, 3) != 0);
      word_i   = W'($urandom);
      bit_en_i = ($urandom_range(0, 3) != 0);
      reset_i  = ($urandom_range(0, 199) != 0);
    end
    @(posedge clk);
    #1;
    reset_i = 1'b1;
    valid_i = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
